// File: rtl/frog_controller.sv
// -----------------------------------------------------------------------------
// frog_controller
//   Player-side controller for the frogger playfield. Decodes WASD keycodes
//   into grid hops, paces each hop, sequences death/respawn, and keeps the
//   lives count, score and game-over flag. One state update per video frame.
//
//   Optional feature (compile-time macro FROG_RESPAWN_GRACE_EN):
//     when defined, every respawn starts a GRACE_FRAMES invulnerability window
//     during which car collisions are ignored.
//
// Ports:
//   frame_clk      in   1          frame-rate clock, all state on rising edge
//   Reset          in   1          asynchronous active-high reset
//   keycode        in   8          USB HID keycode, 0 = no key
//   Car_Collision  in   NUM_LANES  per-lane collision flags, OR-reduced
//   Frog_X         out  11         frog left edge (pixels)
//   Frog_Y         out  11         frog top edge (pixels)
//   Frog_Dir       out  2          facing: 0 up, 1 left, 2 down, 3 right
//   Frog_Dead      out  1          high during death animation / game over
//   Lives          out  3          remaining lives
//   Score          out  10         score, saturates at 999
//   Game_Over      out  1          sticky once lives are exhausted
// -----------------------------------------------------------------------------
module frog_controller #(
    parameter logic [10:0] START_X      = 11'd320,
    parameter logic [10:0] START_Y      = 11'd440,
    parameter logic [10:0] STEP         = 11'd40,
    parameter logic [10:0] X_MAX        = 11'd600,
    parameter logic [10:0] HOME_Y       = 11'd0,
    parameter int          NUM_LANES    = 8,
    parameter int          HOP_FRAMES   = 4,
    parameter int          DEATH_FRAMES = 60,
    parameter int          LIVES_INIT   = 3,
    parameter int          GRACE_FRAMES = 60
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [NUM_LANES-1:0] Car_Collision,
    output logic [10:0]          Frog_X,
    output logic [10:0]          Frog_Y,
    output logic [1:0]           Frog_Dir,
    output logic                 Frog_Dead,
    output logic [2:0]           Lives,
    output logic [9:0]           Score,
    output logic                 Game_Over
);

    localparam int         CNT_MAX   = (DEATH_FRAMES > HOP_FRAMES) ? DEATH_FRAMES : HOP_FRAMES;
    localparam int         CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [9:0] SCORE_MAX = 10'd999;

    typedef enum logic [1:0] {
        ST_ALIVE,
        ST_HOP,
        ST_DYING,
        ST_GAME_OVER
    } state_e;

    state_e           state_q, state_d;
    logic [10:0]      x_q, x_d;
    logic [10:0]      y_q, y_d;
    logic [1:0]       dir_q, dir_d;
    logic             dead_q, dead_d;
    logic [2:0]       lives_q, lives_d;
    logic [9:0]       score_q, score_d;
    logic             over_q, over_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       key_prev_q, key_prev_d;
    logic [10:0]      best_y_q, best_y_d;   // lowest Y reached this life

`ifdef FROG_RESPAWN_GRACE_EN
    localparam int      GRACE_W = $clog2(GRACE_FRAMES + 1);
    logic [GRACE_W-1:0] grace_q, grace_d;
`endif

    logic        key_valid;
    logic        press;
    logic        hit;
    logic        in_bounds;
    logic [1:0]  key_dir;
    logic [11:0] cand_x;
    logic [11:0] cand_y;

    function automatic logic [9:0] sat_add(input logic [9:0] s, input logic [3:0] inc);
        logic [10:0] sum;
        sum = {1'b0, s} + {7'd0, inc};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
    endfunction

`ifdef FROG_RESPAWN_GRACE_EN
    assign hit = (|Car_Collision) && (grace_q == '0);
`else
    assign hit = |Car_Collision;
`endif

    // Candidate position is computed one bit wider so an underflow (X=0 going
    // left, Y=0 going up) shows up in bit 11 and fails the bounds check
    // instead of wrapping to a large legal-looking value.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        key_valid = 1'b1;
        key_dir   = 2'd0;
        cand_x    = {1'b0, x_q};
        cand_y    = {1'b0, y_q};
        case (keycode)
            8'h1A:   begin key_dir = 2'd0; cand_y = {1'b0, y_q} - {1'b0, STEP}; end
            8'h04:   begin key_dir = 2'd1; cand_x = {1'b0, x_q} - {1'b0, STEP}; end
            8'h16:   begin key_dir = 2'd2; cand_y = {1'b0, y_q} + {1'b0, STEP}; end
            8'h07:   begin key_dir = 2'd3; cand_x = {1'b0, x_q} + {1'b0, STEP}; end
            default: key_valid = 1'b0;
        endcase
        // A changed keycode is a fresh press, so W->A without release moves left.
        press     = key_valid && (keycode != key_prev_q);
        in_bounds = !cand_x[11] && (cand_x <= {1'b0, X_MAX}) &&
                    !cand_y[11] && (cand_y >= {1'b0, HOME_Y}) && (cand_y <= {1'b0, START_Y});
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        dead_d     = dead_q;
        lives_d    = lives_q;
        score_d    = score_q;
        over_d     = over_q;
        cnt_d      = cnt_q;
        best_y_d   = best_y_q;
        key_prev_d = keycode;
`ifdef FROG_RESPAWN_GRACE_EN
        grace_d    = (grace_q != '0) ? grace_q - GRACE_W'(1) : grace_q;
`endif

        case (state_q)
            ST_ALIVE, ST_HOP: begin
                if (hit) begin
                    // Death takes priority over any key press or hop completion.
                    state_d = ST_DYING;
                    lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                    cnt_d   = CNT_W'(DEATH_FRAMES - 1);
                    dead_d  = 1'b1;
                end else if (state_q == ST_HOP) begin
                    if (cnt_q == '0) begin
                        state_d = ST_ALIVE;
                        if (y_q == HOME_Y) begin
                            score_d  = sat_add(score_q, 4'd10);
                            x_d      = START_X;
                            y_d      = START_Y;
                            best_y_d = START_Y;
`ifdef FROG_RESPAWN_GRACE_EN
                            grace_d  = GRACE_W'(GRACE_FRAMES);
`endif
                        end else if (y_q < best_y_q) begin
                            score_d  = sat_add(score_q, 4'd1);
                            best_y_d = y_q;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else if (press) begin
                    dir_d = key_dir;
                    if (in_bounds) begin
                        x_d     = cand_x[10:0];
                        y_d     = cand_y[10:0];
                        cnt_d   = CNT_W'(HOP_FRAMES - 1);
                        state_d = ST_HOP;
                    end
                end
            end

            ST_DYING: begin
                if (cnt_q == '0) begin
                    if (lives_q == 3'd0) begin
                        state_d = ST_GAME_OVER;
                        over_d  = 1'b1;
                    end else begin
                        state_d  = ST_ALIVE;
                        x_d      = START_X;
                        y_d      = START_Y;
                        dir_d    = 2'd0;
                        best_y_d = START_Y;
                        dead_d   = 1'b0;
`ifdef FROG_RESPAWN_GRACE_EN
                        grace_d  = GRACE_W'(GRACE_FRAMES);
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                // Game over holds everything until reset.
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_ALIVE;
            x_q        <= START_X;
            y_q        <= START_Y;
            dir_q      <= 2'd0;
            dead_q     <= 1'b0;
            lives_q    <= 3'(LIVES_INIT);
            score_q    <= 10'd0;
            over_q     <= 1'b0;
            cnt_q      <= '0;
            key_prev_q <= 8'd0;
            best_y_q   <= START_Y;
`ifdef FROG_RESPAWN_GRACE_EN
            grace_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            dead_q     <= dead_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            over_q     <= over_d;
            cnt_q      <= cnt_d;
            key_prev_q <= key_prev_d;
            best_y_q   <= best_y_d;
`ifdef FROG_RESPAWN_GRACE_EN
            grace_q    <= grace_d;
`endif
        end
    end

    assign Frog_X    = x_q;
    assign Frog_Y    = y_q;
    assign Frog_Dir  = dir_q;
    assign Frog_Dead = dead_q;
    assign Lives     = lives_q;
    assign Score     = score_q;
    assign Game_Over = over_q;

endmodule

// File: tb/tb_frog_controller.sv
// -----------------------------------------------------------------------------
// tb_frog_controller
//   Self-checking bench for frog_controller. A frame-indexed game model tracks
//   the frog with plain integers and "busy until frame N" deadlines; every
//   frame the packed DUT outputs are compared against it, plus directed
//   checks on the headline values of each scenario.
// -----------------------------------------------------------------------------
module tb_frog_controller;

    localparam int START_X = 320;
    localparam int START_Y = 440;
    localparam int STEP    = 40;
    localparam int X_MAX   = 600;
    localparam int HOME_Y  = 0;
    localparam int HOP     = 4;
    localparam int DEATH   = 60;
    localparam int LIVES0  = 3;
    localparam int GRACE   = 60;

    logic        frame_clk = 1'b0;
    logic        Reset     = 1'b0;
    logic [7:0]  keycode   = 8'd0;
    logic [7:0]  Car_Collision = 8'd0;
    logic [10:0] Frog_X, Frog_Y;
    logic [1:0]  Frog_Dir;
    logic        Frog_Dead;
    logic [2:0]  Lives;
    logic [9:0]  Score;
    logic        Game_Over;

    int vectors     = 0;
    int miscompares = 0;

    frog_controller dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycode       (keycode),
        .Car_Collision (Car_Collision),
        .Frog_X        (Frog_X),
        .Frog_Y        (Frog_Y),
        .Frog_Dir      (Frog_Dir),
        .Frog_Dead     (Frog_Dead),
        .Lives         (Lives),
        .Score         (Score),
        .Game_Over     (Game_Over)
    );

    always #5 frame_clk = ~frame_clk;

    logic [38:0] dut_vec;
    assign dut_vec = {Frog_X, Frog_Y, Frog_Dir, Frog_Dead, Lives, Score, Game_Over};

    // ---------------- behavioural game model ----------------
    int         m_x, m_y, m_dir, m_lives, m_score, m_best, m_f;
    bit         m_hop, m_dying, m_over;
    int         m_hop_end, m_death_end;
    logic [7:0] m_prev;
`ifdef FROG_RESPAWN_GRACE_EN
    int         m_grace_end;
`endif

    function automatic int min999(input int v);
        return (v > 999) ? 999 : v;
    endfunction

    function automatic logic [38:0] model_vec();
        logic dead;
        dead = m_dying || m_over;
        return {11'(m_x), 11'(m_y), 2'(m_dir), dead, 3'(m_lives), 10'(m_score), m_over};
    endfunction

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_dir = 0; m_lives = LIVES0; m_score = 0;
        m_best = START_Y; m_hop = 0; m_dying = 0; m_over = 0; m_prev = 8'd0;
        m_hop_end = -1; m_death_end = -1;
`ifdef FROG_RESPAWN_GRACE_EN
        m_grace_end = -1;
`endif
    endtask

    task automatic model_step(input logic [7:0] k, input bit hitv);
        int dx, dy, nd, nx, ny;
        bit dec, press, hit_eff;
        dec = 1; dx = 0; dy = 0; nd = 0;
        case (k)
            8'h1A:   begin dy = -STEP; nd = 0; end
            8'h04:   begin dx = -STEP; nd = 1; end
            8'h16:   begin dy =  STEP; nd = 2; end
            8'h07:   begin dx =  STEP; nd = 3; end
            default: dec = 0;
        endcase
        press   = dec && (k != m_prev);
        hit_eff = hitv;
`ifdef FROG_RESPAWN_GRACE_EN
        if (m_f <= m_grace_end) hit_eff = 0;
`endif
        if (m_over) begin
            // frozen
        end else if (m_dying) begin
            if (m_f == m_death_end) begin
                if (m_lives == 0) m_over = 1;
                else begin
                    m_dying = 0; m_x = START_X; m_y = START_Y; m_dir = 0; m_best = START_Y;
`ifdef FROG_RESPAWN_GRACE_EN
                    m_grace_end = m_f + GRACE;
`endif
                end
            end
        end else if (hit_eff) begin
            if (m_lives > 0) m_lives = m_lives - 1;
            m_dying = 1; m_hop = 0; m_death_end = m_f + DEATH;
        end else if (m_hop) begin
            if (m_f == m_hop_end) begin
                m_hop = 0;
                if (m_y == HOME_Y) begin
                    m_score = min999(m_score + 10);
                    m_x = START_X; m_y = START_Y; m_best = START_Y;
`ifdef FROG_RESPAWN_GRACE_EN
                    m_grace_end = m_f + GRACE;
`endif
                end else if (m_y < m_best) begin
                    m_score = min999(m_score + 1);
                    m_best  = m_y;
                end
            end
        end else if (press) begin
            m_dir = nd;
            nx = m_x + dx; ny = m_y + dy;
            if (nx >= 0 && nx <= X_MAX && ny >= HOME_Y && ny <= START_Y) begin
                m_x = nx; m_y = ny; m_hop = 1; m_hop_end = m_f + HOP;
            end
        end
        m_prev = k;
        m_f    = m_f + 1;
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input logic [7:0] k, input logic [7:0] c);
        keycode       = k;
        Car_Collision = c;
        @(posedge frame_clk);
        model_step(k, |c);
        #1;
    endtask

    task automatic assert_reset();
        keycode = 8'd0; Car_Collision = 8'd0;
        Reset = 1'b1;
        #2;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge frame_clk);
        #1;
        Reset = 1'b0;
    endtask

    function automatic logic [7:0] rand_key();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 3) return 8'h00;
        if (r == 4) return 8'h1A;
        if (r == 5) return 8'h04;
        if (r == 6) return 8'h16;
        if (r == 7) return 8'h07;
        if (r == 8) return keycode;
        return 8'($urandom_range(0, 255));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [38:0] rst_vec;
        rst_vec = {11'd320, 11'd440, 2'd0, 1'b0, 3'd3, 10'd0, 1'b0};
        assert_reset();
        vectors++;
        if (dut_vec !== rst_vec) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", dut_vec, rst_vec);
        end
        release_reset();
    endtask

    task automatic test_hop_up();
        assert_reset(); release_reset();
        tick(8'h1A, 8'd0);
        vectors++;
        if (Frog_Y !== 11'd400) begin
            miscompares++; $display("FAIL hop_up_y: got %0d want 400", Frog_Y);
        end
        for (int i = 0; i < HOP; i++) begin
            tick(8'h00, 8'd0);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL hop_up_frame%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        vectors++;
        if (Score !== 10'd1) begin
            miscompares++; $display("FAIL hop_up_score: got %0d want 1", Score);
        end
    endtask

    task automatic test_hold_and_edge();
        assert_reset(); release_reset();
        for (int i = 0; i < 20; i++) begin
            tick(8'h07, 8'd0);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL hold_d_frame%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        vectors++;
        if (Frog_X !== 11'd360 || Frog_Dir !== 2'd3) begin
            miscompares++; $display("FAIL hold_d_once: got x=%0d dir=%0d want x=360 dir=3", Frog_X, Frog_Dir);
        end
        for (int p = 0; p < 9; p++) begin
            tick(8'h04, 8'd0);
            for (int i = 0; i < HOP; i++) tick(8'h00, 8'd0);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL walk_left%0d: got %h want %h", p, dut_vec, model_vec());
            end
        end
        for (int i = 0; i < 10; i++) tick(8'h04, 8'd0);
        vectors++;
        if (Frog_X !== 11'd0 || Frog_Dir !== 2'd1) begin
            miscompares++; $display("FAIL left_edge: got x=%0d dir=%0d want x=0 dir=1", Frog_X, Frog_Dir);
        end
    endtask

    task automatic test_collision();
        assert_reset(); release_reset();
        tick(8'h1A, 8'h04);
        vectors++;
        if (Lives !== 3'd2 || Frog_Dead !== 1'b1 || Frog_Y !== 11'd440) begin
            miscompares++;
            $display("FAIL hit_entry: got lives=%0d dead=%0b y=%0d want lives=2 dead=1 y=440", Lives, Frog_Dead, Frog_Y);
        end
        for (int i = 0; i < DEATH; i++) begin
            tick(8'h00, 8'd0);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL dying_frame%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        vectors++;
        if (Frog_X !== 11'd320 || Frog_Y !== 11'd440 || Frog_Dead !== 1'b0) begin
            miscompares++;
            $display("FAIL respawn: got x=%0d y=%0d dead=%0b want x=320 y=440 dead=0", Frog_X, Frog_Y, Frog_Dead);
        end
    endtask

    task automatic test_home_and_saturation();
        assert_reset(); release_reset();
        for (int p = 0; p < 11; p++) begin
            tick(8'h1A, 8'd0);
            for (int i = 0; i < HOP; i++) tick(8'h00, 8'd0);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL climb%0d: got %h want %h", p, dut_vec, model_vec());
            end
        end
        vectors++;
        if (Score !== 10'd20 || Frog_X !== 11'd320 || Frog_Y !== 11'd440) begin
            miscompares++;
            $display("FAIL home: got score=%0d x=%0d y=%0d want score=20 x=320 y=440", Score, Frog_X, Frog_Y);
        end
        for (int t = 0; t < 50; t++) begin
            for (int p = 0; p < 11; p++) begin
                tick(8'h1A, 8'd0);
                for (int i = 0; i < HOP; i++) tick(8'h00, 8'd0);
            end
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL trip%0d: got %h want %h", t, dut_vec, model_vec());
            end
        end
        vectors++;
        if (Score !== 10'd999) begin
            miscompares++; $display("FAIL score_saturate: got %0d want 999", Score);
        end
    endtask

    task automatic test_game_over();
        assert_reset(); release_reset();
        for (int d = 0; d < LIVES0; d++) begin
            tick(8'h00, 8'h01);
            for (int i = 0; i < DEATH; i++) tick(8'h00, 8'd0);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL death%0d: got %h want %h", d, dut_vec, model_vec());
            end
        end
        vectors++;
        if (Game_Over !== 1'b1 || Lives !== 3'd0 || Frog_Dead !== 1'b1) begin
            miscompares++;
            $display("FAIL game_over: got over=%0b lives=%0d dead=%0b want 1 0 1", Game_Over, Lives, Frog_Dead);
        end
        for (int i = 0; i < 30; i++) begin
            tick(rand_key(), 8'($urandom_range(0, 255)));
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL over_frozen%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        // Reset in the middle of a death animation.
        assert_reset(); release_reset();
        tick(8'h1A, 8'h00);
        tick(8'h00, 8'h80);
        for (int i = 0; i < 25; i++) tick(8'h00, 8'd0);
        assert_reset();
        vectors++;
        if (dut_vec !== {11'd320, 11'd440, 2'd0, 1'b0, 3'd3, 10'd0, 1'b0}) begin
            miscompares++; $display("FAIL reset_mid_dying: got %h want %h", dut_vec, model_vec());
        end
        release_reset();
    endtask

    task automatic test_grace();
        int want_lives;
        assert_reset(); release_reset();
`ifdef FROG_RESPAWN_GRACE_EN
        want_lives = 2;
`else
        want_lives = 1;
`endif
        for (int i = 0; i < 140; i++) begin
            tick(8'h00, 8'hFF);
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++; $display("FAIL held_hit_frame%0d: got %h want %h", i, dut_vec, model_vec());
            end
            if (i == 61) begin
                vectors++;
                if (Lives !== 3'(want_lives)) begin
                    miscompares++; $display("FAIL grace_lives: got %0d want %0d", Lives, want_lives);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        for (int r = 0; r < 4; r++) begin
            assert_reset(); release_reset();
            for (int i = 0; i < 700; i++) begin
                c = ($urandom_range(0, 99) < 2) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
                tick(rand_key(), c);
                vectors++;
                if (dut_vec !== model_vec()) begin
                    miscompares++; $display("FAIL random_r%0d_f%0d: got %h want %h", r, i, dut_vec, model_vec());
                end
            end
        end
    endtask

    initial begin
        m_f = 0;
        model_reset();
        test_reset();
        test_hop_up();
        test_hold_and_edge();
        test_collision();
        test_home_and_saturation();
        test_game_over();
        test_grace();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frog_controller.md
Name: frog_controller

Overview:
Player-side counterpart to the lane car blocks.
- Consumes keyboard keycodes and the per-lane Car_Collision flags.
- Produces the frog's grid position, which is fed back to every car's Frog_X/Frog_Y inputs.
- Owns hop pacing, death/respawn sequencing, the lives count, score and game-over.
- Runs on frame_clk (one tick per video frame) alongside the car blocks.

Parameters:
START_X, 11'd320, respawn X (pixels)
START_Y, 11'd440, respawn Y (bottom row)
STEP, 11'd40, hop distance = frog side = lane height
X_MAX, 11'd600, largest legal Frog_X
HOME_Y, 11'd0, goal row Y
NUM_LANES, 8, width of collision input vector
HOP_FRAMES, 4, frames a hop occupies (keys locked out)
DEATH_FRAMES, 60, frames the death animation lasts
LIVES_INIT, 3, lives at reset (1..7)
GRACE_FRAMES, 60, post-respawn invulnerability (optional feature only)

Ports:
frame_clk  in  1  frame-rate clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
keycode  in  8  USB HID keycode, 0 = no key
Car_Collision  in  NUM_LANES  collision flags from car blocks, OR-reduced internally
Frog_X  out  11  frog left edge, pixels
Frog_Y  out  11  frog top edge, pixels
Frog_Dir  out  2  facing: 0 up, 1 left, 2 down, 3 right (sprite select)
Frog_Dead  out  1  high during death animation
Lives  out  3  remaining lives
Score  out  10  score, saturates at 999
Game_Over  out  1  high once lives exhausted, sticky

Behaviour:
- Reset values (async, immediate):
  - Frog_X=START_X, Frog_Y=START_Y, Frog_Dir=0.
  - Frog_Dead=0, Lives=LIVES_INIT, Score=0, Game_Over=0.
  - state=ALIVE; counter=0; key_prev=0.
  - best_y=START_Y (lowest Y reached this life).
- Key decode: W=0x1A up (Y-STEP), A=0x04 left (X-STEP), S=0x16 down (Y+STEP), D=0x07 right (X+STEP). All other codes are ignored.
- Press = decoded direction AND keycode != key_prev. key_prev is registered every frame in all states.
  - A held key never repeats.
  - W→A without release counts as an A press.
- hit = |Car_Collision, sampled at the edge.
- States:
  - ALIVE:
    - Priority 1: hit → DYING. Lives-=1 (saturate 0); counter=DEATH_FRAMES-1; position frozen.
    - Priority 2: press → Frog_Dir updated.
      - Move in bounds (0≤X≤X_MAX, HOME_Y≤Y≤START_Y): position updated the same edge; counter=HOP_FRAMES-1; → HOP.
      - Move out of bounds: position unchanged, stay ALIVE.
  - HOP:
    - Presses ignored. counter-=1 per frame.
    - hit → DYING, same rules as ALIVE.
    - At counter==0:
      - If Frog_Y==HOME_Y: Score+=10; position=start; best_y=START_Y.
      - Else if Frog_Y<best_y: Score+=1; best_y=Frog_Y.
      - → ALIVE.
  - DYING:
    - Frog_Dead=1; hit and keys ignored; counter-=1.
    - At counter==0:
      - Lives==0 → GAME_OVER.
      - Else position=start, Frog_Dir=0, best_y=START_Y, Frog_Dead=0 → ALIVE.
  - GAME_OVER: Game_Over=1, Frog_Dead=1; all inputs ignored; exit only by Reset.
- Score additions saturate at 999, never wrap.
- Arithmetic is 11-bit unsigned. The bounds check is done on the candidate before committing, so X=0 with A never wraps to 2047.
- All outputs are registered; Frog_X/Y change exactly one edge after the press is sampled.
- Reset asserted mid-hop or mid-death returns everything to reset values; no pending score is applied.

Optional Feature:
FROG_RESPAWN_GRACE_EN
- Defined:
  - On every respawn (DYING→ALIVE and home-reset) a grace counter loads GRACE_FRAMES. It decrements each frame to 0.
  - While it is non-zero, hit is masked in ALIVE and HOP. Movement is allowed.
  - Reset clears the grace counter.
- Undefined: no grace counter exists; hit is honoured immediately after respawn.

Test Plan:
1. Reset, keycode=0x1A for 1 frame then 0 → Frog_Y=400 one edge later; HOP 4 frames; then Score=1, state ALIVE.
2. Hold keycode=0x07 for 20 frames → exactly one hop, Frog_X=360, Frog_Dir=3. Hold 0x04 at Frog_X=0 → Frog_X stays 0, Frog_Dir=1.
3. Car_Collision=8'h04 for 1 frame while ALIVE with a simultaneous W press → Lives=2, Frog_Dead=1, Frog_Y unchanged. After 60 frames Frog_X=320, Frog_Y=440, Frog_Dead=0.
4. Eleven successful W presses from start → Frog_Y=0, Score=10+10=20, frog back at (320,440).
5. Three collisions → Lives=0; after the third death animation Game_Over=1; further keys/collisions do nothing. Assert Reset mid-DYING → all reset values.
6. With FROG_RESPAWN_GRACE_EN: collision held high continuously → one death, then no further Lives decrement for 60 frames after respawn. Without the macro → second death on the first ALIVE frame after respawn.
